// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helper for the parameterised synchronous FIFO.
package sync_fifo_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;

  // Pointer width for n entries; count width is this plus one so DEPTH itself fits.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// Data/handshake/status bundle between the FIFO and its user.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] DIN;
  logic             WRITE;
  logic             READ;
  logic             FLUSH;
  logic [WIDTH-1:0] DOUT;
  logic             EMPTY;
  logic             FULL;
  logic             ALMOST_FULL;
  logic             ALMOST_EMPTY;
  logic [CW-1:0]    COUNT;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  modport master (
    output DIN, WRITE, READ, FLUSH,
    input  DOUT, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
  );
  modport slave (
    input  DIN, WRITE, READ, FLUSH,
    output DOUT, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// Storage array: one write port, one registered read port. Only the read register resets.
module sync_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Same-address read and write return the old word (read-before-write).
  always_ff @(posedge clk)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with registered status flags, sticky over/underflow and flush.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (AF_LEVEL > DEPTH || AF_LEVEL < 0) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL out of range");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
  end

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt, cnt_d;
  logic          empty_q, full_q, af_q, ae_q, ovf_q, unf_q;
  logic          wr_ok, rd_ok, idle;

  assign idle  = RESET | bus.FLUSH;
  assign rd_ok = bus.READ & ~empty_q;
  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign wr_ok = bus.WRITE & (~full_q | rd_ok);

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    cnt_d = idle ? '0 : count_nxt;
  end

  always_ff @(posedge CLK) begin
    if (idle) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      count <= count_nxt;
    end
    // Flags track next-state occupancy so they line up with COUNT.
    empty_q <= (cnt_d == '0);
    full_q  <= (cnt_d == FULL_C);
    af_q    <= (cnt_d >= AF_C);
    ae_q    <= (cnt_d <= AE_C);
    if (RESET) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!bus.FLUSH) begin
      ovf_q <= ovf_q | (bus.WRITE & ~wr_ok);
      unf_q <= unf_q | (bus.READ & ~rd_ok);
    end
  end

  sync_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (CLK),
    .rst   (RESET),
    .we    (wr_ok & ~idle),
    .waddr (wptr),
    .wdata (bus.DIN),
    .re    (rd_ok & ~idle),
    .raddr (rptr),
    .rdata (bus.DOUT)
  );

  assign bus.COUNT        = count;
  assign bus.EMPTY        = empty_q;
  assign bus.FULL         = full_q;
  assign bus.ALMOST_FULL  = af_q;
  assign bus.ALMOST_EMPTY = ae_q;
  assign bus.OVERFLOW     = ovf_q;
  assign bus.UNDERFLOW    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed and randomized checks of sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] q[$];
  logic [31:0] m_dout;
  bit          m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("dout",   bus.DOUT, m_dout);
    chk("count",  32'(bus.COUNT), n);
    chk("empty",  32'(bus.EMPTY), 32'(n == 0));
    chk("full",   32'(bus.FULL), 32'(n == DEPTH));
    chk("afull",  32'(bus.ALMOST_FULL), 32'(n >= AF));
    chk("aempty", 32'(bus.ALMOST_EMPTY), 32'(n <= AE));
    chk("ovf",    32'(bus.OVERFLOW), 32'(m_ovf));
    chk("unf",    32'(bus.UNDERFLOW), 32'(m_unf));
  endtask

  // Drive one cycle of inputs, advance the model by the FIFO's rules, then compare.
  task automatic cyc(input bit r, input bit w, input bit rd, input bit f, input logic [31:0] d);
    bit rok, wok;
    rst = r; bus.WRITE = w; bus.READ = rd; bus.FLUSH = f; bus.DIN = d;
    if (r) begin
      q.delete(); m_dout = '0; m_ovf = 0; m_unf = 0;
    end else if (f) begin
      q.delete();
    end else begin
      rok = rd && (q.size() != 0);
      wok = w && (q.size() < DEPTH || rok);
      if (rok) m_dout = q.pop_front();
      if (wok) q.push_back(d);
      if (w && !wok) m_ovf = 1;
      if (rd && !rok) m_unf = 1;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    bit r, w, rd, f;
    // reset state
    cyc(1, 0, 0, 0, 0);
    chk("rst_empty", 32'(bus.EMPTY), 1);
    chk("rst_dout", bus.DOUT, 0);

    // fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 0, 32'h11 * i);
      chk("fill_count", 32'(bus.COUNT), i);
    end
    chk("fill_full", 32'(bus.FULL), 1);

    // write into full FIFO is dropped
    cyc(0, 1, 0, 0, 32'h99);
    chk("ovf_set", 32'(bus.OVERFLOW), 1);
    chk("ovf_count", 32'(bus.COUNT), 8);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 0, 0);
      chk("drain_dout", bus.DOUT, 32'h11 * i);
    end

    // simultaneous read/write while full
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 0, 32'h11 * i);
    cyc(0, 1, 1, 0, 32'hAA);
    chk("rw_full_dout", bus.DOUT, 32'h11);
    chk("rw_full_count", 32'(bus.COUNT), 8);
    chk("rw_full_ovf", 32'(bus.OVERFLOW), 0);
    for (int i = 2; i <= 8; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("aa_last", bus.DOUT, 32'hAA);

    // read+write into empty: read rejected, write accepted
    cyc(0, 1, 1, 0, 32'h5A);
    chk("unf_set", 32'(bus.UNDERFLOW), 1);
    chk("empty_rw_count", 32'(bus.COUNT), 1);
    chk("dout_hold", bus.DOUT, 32'hAA);
    cyc(0, 0, 1, 0, 0);
    chk("dout_5a", bus.DOUT, 32'h5A);

    // streaming with a 3-entry offset, pointers wrap
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 32'h100 + i);
    for (int i = 3; i < 23; i++) begin
      cyc(0, 1, 1, 0, 32'h100 + i);
      chk("stream_order", bus.DOUT, 32'h100 + i - 3);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    chk("stream_last", bus.DOUT, 32'h100 + 22);
    chk("stream_ovf", 32'(bus.OVERFLOW), 0);
    chk("stream_unf", 32'(bus.UNDERFLOW), 0);

    // flush at COUNT=5 with sticky OVERFLOW already set
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 32'h200 + i);
    cyc(0, 1, 0, 0, 32'hDEAD);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    chk("pre_flush_count", 32'(bus.COUNT), 5);
    cyc(0, 1, 1, 1, 32'hBEEF);
    chk("flush_count", 32'(bus.COUNT), 0);
    chk("flush_ovf", 32'(bus.OVERFLOW), 1);
    chk("flush_unf", 32'(bus.UNDERFLOW), 0);
    chk("flush_dout", bus.DOUT, 32'h202);

    // reset mid-burst
    for (int i = 0; i < 4; i++) cyc(0, 1, i[0], 0, 32'h300 + i);
    cyc(1, 1, 1, 0, 32'h3FF);
    chk("midrst_count", 32'(bus.COUNT), 0);
    chk("midrst_dout", bus.DOUT, 0);
    chk("midrst_ovf", 32'(bus.OVERFLOW), 0);

    // randomized traffic, biased to visit both full and empty
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 79) == 0);
      w  = ($urandom_range(0, 3) < ((i / 100) % 2 == 0 ? 3 : 1));
      rd = ($urandom_range(0, 3) < ((i / 100) % 2 == 0 ? 1 : 3));
      cyc(r, w, rd, f, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
